serial_mag_comparator: RTL and testbench

Sequential WIDTH-bit unsigned magnitude comparator. It time-shares a single instance of the team's 1-bit mux-based comparator cell (`comparator_4x1mux`) across all bit positions, scanning MSB to LSB. It exits early on the first differing bit. It is used wherever a wide compare is needed rarely enough that one bit-cell per cycle is cheaper than a parallel comparator tree.

---
 rtl/serial_mag_comparator.sv | 124 ++++++++++++
 tb/tb_serial_mag_comparator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: one mux-based 1-bit cell is reused
// for every bit position, scanning MSB to LSB and stopping at the first difference.

module comparator_4x1mux (
    input  logic a,
    input  logic b,
    output logic greater,
    output logic lesser,
    output logic equal
);
    // Each flag is a 4:1 mux selected by {a,b}, with the truth table on its data inputs
    localparam logic [3:0] GREATER_TABLE = 4'b0100;
    localparam logic [3:0] LESSER_TABLE  = 4'b0010;
    localparam logic [3:0] EQUAL_TABLE   = 4'b1001;

    logic [1:0] sel;

    assign sel     = {a, b};
    assign greater = GREATER_TABLE[sel];
    assign lesser  = LESSER_TABLE[sel];
    assign equal   = EQUAL_TABLE[sel];
endmodule

module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_reg, a_nxt;
    logic [WIDTH-1:0] b_reg, b_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            done_nxt, greater_nxt, lesser_nxt, equal_nxt;
    logic            cell_greater, cell_lesser, cell_equal;

    comparator_4x1mux u_cell (
        .a       (a_reg[idx]),
        .b       (b_reg[idx]),
        .greater (cell_greater),
        .lesser  (cell_lesser),
        .equal   (cell_equal)
    );

    assign busy = (state == COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            idx     <= '0;
            done    <= 1'b0;
            greater <= 1'b0;
            lesser  <= 1'b0;
            equal   <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_reg   <= a_nxt;
            b_reg   <= b_nxt;
            idx     <= idx_nxt;
            done    <= done_nxt;
            greater <= greater_nxt;
            lesser  <= lesser_nxt;
            equal   <= equal_nxt;
        end
    end

    // Flags hold their last result in IDLE; done defaults low so it only pulses
    always_comb begin
        state_nxt   = state;
        a_nxt       = a_reg;
        b_nxt       = b_reg;
        idx_nxt     = idx;
        done_nxt    = 1'b0;
        greater_nxt = greater;
        lesser_nxt  = lesser;
        equal_nxt   = equal;

        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt       = a;
                    b_nxt       = b;
                    idx_nxt     = IW'(WIDTH - 1);
                    greater_nxt = 1'b0;
                    lesser_nxt  = 1'b0;
                    equal_nxt   = 1'b0;
                    state_nxt   = COMPARE;
                end
            end
            COMPARE: begin
                if (cell_greater || cell_lesser) begin
                    greater_nxt = cell_greater;
                    lesser_nxt  = cell_lesser;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end else if (cell_equal && (idx == '0)) begin
                    equal_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx - IW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed self-checking bench for serial_mag_comparator with WIDTH=8.

module tb_serial_mag_comparator;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             lesser;
    logic             equal;

    int checks;
    int errors;

    serial_mag_comparator #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .greater (greater),
        .lesser  (lesser),
        .equal   (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {59'd0, busy, done, greater, lesser, equal}, 64'd0);
    endtask

    // Starts a compare at the next edge (E0) and follows it to its done edge.
    // ignore_mask[k] pulses start with decoy operands just before edge Ek.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a_v,
                                 input logic [WIDTH-1:0] b_v, input int exp_edge,
                                 input logic [2:0] exp_flags, input logic [15:0] ignore_mask,
                                 input bit check_after);
        int done_edge;
        int busy_gaps;
        int flag_leaks;
        a = a_v;
        b = b_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, "_e0_busy"}, busy, 1'b1);
        checkOutput({tag, "_e0_flags"}, {greater, lesser, equal}, 3'b000);
        done_edge = -1;
        busy_gaps = 0;
        flag_leaks = 0;
        for (int k = 1; k <= 12 && done_edge < 0; k++) begin
            if (ignore_mask[k]) begin
                a = '0;
                b = '1;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                done_edge = k;
            end else begin
                if (!busy) busy_gaps++;
                if (greater || lesser || equal) flag_leaks++;
            end
        end
        checkOutput({tag, "_done_edge"}, done_edge, exp_edge);
        checkOutput({tag, "_flags"}, {greater, lesser, equal}, exp_flags);
        checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
        checkOutput({tag, "_busy_gaps"}, busy_gaps, 0);
        checkOutput({tag, "_flag_leaks"}, flag_leaks, 0);
        if (check_after) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_done_pulse"}, done, 1'b0);
            checkOutput({tag, "_flags_hold"}, {greater, lesser, equal}, exp_flags);
        end
    endtask

    initial begin
        int late_dones;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        // Reset held with activity on the inputs
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            a = 8'h80;
            b = 8'h01 + 8'(i);
            @(posedge clk);
            #1;
        end
        checkAllZero("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;

        // {greater, lesser, equal}
        applyStimulus("eq_a5", 8'hA5, 8'hA5, 8, 3'b001, 16'h0000, 1'b1);
        applyStimulus("gt_msb", 8'h80, 8'h7F, 1, 3'b100, 16'h0000, 1'b1);
        applyStimulus("lt_lsb", 8'h12, 8'h13, 8, 3'b010, 16'h0000, 1'b1);
        applyStimulus("lt_p6", 8'h3C, 8'h5C, 2, 3'b010, 16'h0000, 1'b1);

        // Starts during busy are ignored; back-to-back start in the done cycle is taken
        applyStimulus("ignore", 8'hFF, 8'hFF, 8, 3'b001, 16'h0014, 1'b0);
        applyStimulus("b2b", 8'h01, 8'h00, 8, 3'b100, 16'h0000, 1'b1);

        // Asynchronous reset mid-compare
        a = 8'h0F;
        b = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mid_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkAllZero("mid_rst_immediate");
        @(posedge clk);
        #1;
        rst = 1'b0;
        late_dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) late_dones++;
        end
        checkOutput("mid_rst_no_done", late_dones, 0);
        applyStimulus("after_rst", 8'hFF, 8'h00, 1, 3'b100, 16'h0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
